bus_packet_checker: RTL

- Downstream consumer of the bus word-splitter stage.
- Takes the word-reversed bus and the per-word non-zero flags, and runs a packet-sequence state machine over them.
- Checks each packet's header word and its incrementing sequence word.
- Reports state, error, expected sequence and a packet count to the top level.

---
 rtl/bus_packet_checker.sv | 97 +++++++++
 1 files changed

// File: rtl/bus_packet_checker.sv
// rtl/bus_packet_checker.sv - packet header/sequence checker FSM over the word-reversed bus
module bus_packet_checker #(
    parameter int                 BUS_SIZE  = 16,
    parameter int                 WORD_SIZE = 4,
    parameter int                 WORD_NUM  = BUS_SIZE / WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] HEADER  = 4'hF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_SIZE-1:0]  data_in,
    input  logic [WORD_NUM-1:0]  control_in,
    output logic [2:0]           state_out,
    output logic                 error_out,
    output logic [WORD_SIZE-1:0] exp_seq_out,
    output logic [7:0]           pkt_count
);

    localparam logic [2:0] ST_RESET     = 3'd0;
    localparam logic [2:0] ST_FIRST_PKT = 3'd1;
    localparam logic [2:0] ST_REG_PKT   = 3'd2;
    localparam logic [2:0] ST_F_ERR     = 3'd3;
    localparam logic [2:0] ST_SEQ_ERR   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic                 err_q, err_d;
    logic [WORD_SIZE-1:0] exp_seq_q, exp_seq_d;
    logic [7:0]           cnt_q, cnt_d;

    logic [WORD_SIZE-1:0] hdr_word;
    logic [WORD_SIZE-1:0] seq_word;
    logic                 pkt;
    logic                 hdr_ok;
    logic                 seq_ok;
    logic [7:0]           cnt_inc;

    // Words arrive reversed but flags do not, so the header's flag is bit 0.
    assign hdr_word = data_in[BUS_SIZE-1 -: WORD_SIZE];
    assign seq_word = data_in[WORD_SIZE-1:0];
    assign pkt      = control_in[0];
    assign hdr_ok   = (hdr_word == HEADER);
    assign seq_ok   = (seq_word == exp_seq_q);
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        exp_seq_d = exp_seq_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_RESET: state_d = ST_FIRST_PKT;
            ST_FIRST_PKT, ST_F_ERR, ST_SEQ_ERR: begin
                if (pkt) begin
                    if (!hdr_ok) begin
                        state_d = ST_F_ERR;
                    end else begin
                        state_d   = ST_REG_PKT;
                        exp_seq_d = seq_word + 1'b1;
                        cnt_d     = cnt_inc;
                    end
                end
            end
            ST_REG_PKT: begin
                if (pkt) begin
                    if (!hdr_ok) begin
                        state_d = ST_F_ERR;
                    end else if (seq_ok) begin
                        exp_seq_d = exp_seq_q + 1'b1;
                        cnt_d     = cnt_inc;
                    end else begin
                        state_d = ST_SEQ_ERR;
                    end
                end
            end
            default: state_d = ST_FIRST_PKT;
        endcase
        err_d = (state_d == ST_F_ERR) || (state_d == ST_SEQ_ERR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_RESET;
            err_q     <= 1'b0;
            exp_seq_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            exp_seq_q <= exp_seq_d;
            cnt_q     <= cnt_d;
        end
    end

    assign state_out   = state_q;
    assign error_out   = err_q;
    assign exp_seq_out = exp_seq_q;
    assign pkt_count   = cnt_q;

endmodule
